alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle 32-bit ALU. Accepts one operation per transaction over a valid/ready input channel and returns a registered result, status flags and tag over a valid/ready output channel. Logic and arithmetic ops complete in one cycle. Multiply and divide run as iterative multi-cycle operations. Sits between the decode/operand-fetch stage and writeback of the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of 2)
TAG_W, 4, width of opaque tag carried from request to response

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept request
op  in  4  operation code
a  in  WIDTH  operand A
b  in  WIDTH  operand B
tag_in  in  TAG_W  request tag
out_valid  out  1  response valid
out_ready  in  1  consumer accepts response
result  out  WIDTH  result
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
carry  out  1  ADD carry-out / SUB borrow
overflow  out  1  signed overflow of ADD/SUB
illegal  out  1  op not supported
tag_out  out  TAG_W  tag of this response

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits), 1110 DIVU, 1111 REMU.
- Opcodes 1011 and 1101 are illegal: result=0, illegal=1, other flags 0, single-cycle.
- Shift amount = b[$clog2(WIDTH)-1:0]. SLT/SLTU produce 1 or 0 zero-extended.
- carry: ADD = carry-out; SUB = 1 when a<b unsigned (borrow); 0 for all other ops.
- overflow: signed overflow for ADD/SUB only; 0 otherwise.
- zero and negative are computed from the final result for every op, including illegal.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready; operands, op and tag are captured.
- Single-cycle op: IDLE -> DONE. out_valid=1 on the cycle after acceptance (latency 1).
- MUL: IDLE -> BUSY. Shift-add, one bit per cycle, WIDTH iterations, then DONE. out_valid asserts WIDTH+1 cycles after acceptance.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations. Same latency as MUL.
- Divide by zero: no iteration, latency 1. DIVU result = all ones; REMU result = a.
- DONE: out_valid=1. result, flags and tag_out are held stable until out_ready=1, then the FSM returns to IDLE. No new request is accepted in the DONE cycle (in_ready=0 in BUSY and DONE). Maximum throughput is 1 op per 2 cycles.
- in_valid is ignored outside IDLE. Input operands may change freely after acceptance.
- Reset (any state, including mid-iteration): the FSM goes to IDLE, in-flight op is discarded. Reset values: out_valid=0, result=0, all flags=0, tag_out=0, in_ready=1 on the first cycle after reset.

Optional Feature:
Macro ALU_SEQ_MULDIV_EN.
- Defined: MUL, DIVU and REMU are implemented as above.
- Undefined: the multiplier/divider datapath is not compiled. 1100/1110/1111 are treated as illegal opcodes (result=0, illegal=1, latency 1) and the BUSY state is unreachable.

Test Plan:
All scenarios use WIDTH=32.
- Reset then idle -> in_ready=1, out_valid=0, result=0, all flags 0.
- ADD a=0xFFFFFFFF, b=1, tag=3 -> 1 cycle later: result=0, zero=1, carry=1, overflow=0, tag_out=3.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, negative=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1.
- SLTU with the same operands -> result=0.
- SRA a=0x80000000, b=0x1F -> result=0xFFFFFFFF.
- MUL a=7, b=6 (macro defined) -> out_valid exactly 33 cycles after acceptance, result=42, in_ready=0 throughout.
- DIVU a=100, b=7 -> result=14; REMU -> result=2; DIVU b=0 -> result=0xFFFFFFFF with latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, no new request accepted.
- Assert rst mid-MUL at iteration 10 -> next cycle out_valid=0, in_ready=1; a following ADD 2+3 returns result=5.
- op=1101 -> illegal=1, result=0, zero=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response channel bundle for alu_seq.
//   Request  (master -> slave): in_valid, op, a, b, tag_in   | in_ready back
//   Response (slave -> master): out_valid, result, zero, negative, carry,
//                               overflow, illegal, tag_out   | out_ready back
//   Parameters: WIDTH (operand/result width), TAG_W (opaque tag width).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, op, a, b, tag_in, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow,
           illegal, tag_out
  );

  modport slave (
    input  in_valid, op, a, b, tag_in, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow,
           illegal, tag_out
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU between operand fetch and writeback.
//   One request is accepted in IDLE (in_valid && in_ready); the response is
//   held in DONE until out_ready. Logic/arith ops take one cycle; MUL/DIVU/REMU
//   iterate one bit per cycle for WIDTH cycles (divide by zero is immediate).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - alu_seq_if.slave (request channel in, response channel out)
// Build option:
//   ALU_SEQ_MULDIV_EN - when defined, MUL/DIVU/REMU are built; otherwise
//   opcodes 1100/1110/1111 report illegal and BUSY is never entered.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic    clk,
  input logic    rst,
  alu_seq_if.slave bus
);

  localparam int unsigned SH = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, neg_q, carry_q, ovf_q, ill_q;
  logic [TAG_W-1:0] tag_q;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_ill, multi;
  logic [WIDTH:0]   sum, dif;
  logic [SH-1:0]    shamt;
  logic             accept;

  assign accept = (state == IDLE) && bus.in_valid;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [SH-1:0] LAST = SH'(WIDTH - 1);

  // Shared iteration registers.
  //   MUL : acc = partial product, x = shifted multiplicand, y = multiplier
  //   DIV : acc = partial remainder, x = dividend shifting out / quotient
  //         shifting in, y = divisor
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [SH-1:0]    cnt_q;
  logic             div_q, is_rem_q;
  logic [WIDTH-1:0] acc_n, x_n, y_n, md_res;
  logic [WIDTH:0]   rem_sh, rem_dif;

  always_comb begin
    acc_n   = acc_q;
    x_n     = x_q;
    y_n     = y_q;
    md_res  = '0;
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, y_q};
    if (div_q) begin
      // Restoring step: the sign of rem_dif says whether the divisor fits.
      if (!rem_dif[WIDTH]) begin
        acc_n = rem_dif[WIDTH-1:0];
        x_n   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = rem_sh[WIDTH-1:0];
        x_n   = {x_q[WIDTH-2:0], 1'b0};
      end
      md_res = is_rem_q ? acc_n : x_n;
    end else begin
      acc_n  = acc_q + (y_q[0] ? x_q : '0);
      x_n    = x_q << 1;
      y_n    = y_q >> 1;
      md_res = acc_n;
    end
  end
`endif

  // Single-cycle result, evaluated straight from the request inputs.
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    dif    = {1'b0, bus.a} - {1'b0, bus.b};
    shamt  = bus.b[SH-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    multi  = 1'b0;
    case (bus.op)
      4'b0000: sc_res = bus.a & bus.b;
      4'b0001: sc_res = bus.a | bus.b;
      4'b0010: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0011: sc_res = bus.a ^ bus.b;
      4'b0100: sc_res = ~(bus.a | bus.b);
      4'b0101: sc_res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
      4'b0110: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1000: sc_res = bus.a << shamt;
      4'b1001: sc_res = bus.a >> shamt;
      4'b1010: sc_res = $signed(bus.a) >>> shamt;
`ifdef ALU_SEQ_MULDIV_EN
      4'b1100: multi = 1'b1;
      4'b1110: if (bus.b == '0) sc_res = '1;    else multi = 1'b1;
      4'b1111: if (bus.b == '0) sc_res = bus.a; else multi = 1'b1;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = multi ? BUSY : DONE;
`ifdef ALU_SEQ_MULDIV_EN
      BUSY: if (cnt_q == LAST) state_n = DONE;
`else
      BUSY: state_n = IDLE;
`endif
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      tag_q    <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      is_rem_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        tag_q <= bus.tag_in;
        if (!multi) begin
          res_q   <= sc_res;
          zero_q  <= (sc_res == '0);
          neg_q   <= sc_res[WIDTH-1];
          carry_q <= sc_c;
          ovf_q   <= sc_v;
          ill_q   <= sc_ill;
        end
`ifdef ALU_SEQ_MULDIV_EN
        else begin
          acc_q    <= '0;
          x_q      <= bus.a;
          y_q      <= bus.b;
          cnt_q    <= '0;
          div_q    <= bus.op[1];
          is_rem_q <= bus.op[0];
        end
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      if (state == BUSY) begin
        acc_q <= acc_n;
        x_q   <= x_n;
        y_q   <= y_n;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_q   <= md_res;
          zero_q  <= (md_res == '0);
          neg_q   <= md_res[WIDTH-1];
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          ill_q   <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
  assign bus.tag_out   = tag_q;

endmodule
